mmcm_rst_ctrl: RTL and testbench

MMCM_RST_CTRL -- requirements
Module: mmcm_rst_ctrl

---
 rtl/clk_rst_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/mmcm_rst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mmcm_rst_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset sequencing blocks: controller state
// encoding, default timing parameters and small helpers.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT     = 65536;
  localparam int DEF_STABLE_CYCLES    = 1024;
  localparam int DEF_MAX_RETRIES      = 3;

  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Both stages clear on the asynchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q_r  <= 1'b0;
    end else begin
      meta <= d;
      q_r  <= meta;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mmcm_rst_ctrl.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a qualified lock,
// releases downstream reset, and retries or gives up when lock never settles.
module mmcm_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               locked_in,
  input  logic               relock_req,
  output logic               mmcm_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  if (RST_PULSE_CYCLES < 1) begin : g_bad_rst_pulse
    $fatal(1, "RST_PULSE_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
    $fatal(1, "LOCK_TIMEOUT must be at least 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $fatal(1, "STABLE_CYCLES must be at least 1");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 3) begin : g_bad_max_retries
    $fatal(1, "MAX_RETRIES must be in the range 1..3");
  end

  localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LD_WAIT = CNT_W'(LOCK_TIMEOUT);
  // The cycle in which WAIT sees lock already counts as the first stable cycle.
  localparam logic [CNT_W-1:0] LD_STAB = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic               locked_s;
  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [LOSS_W-1:0]  loss_nxt;
  logic               attempt_failed;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (RESET),
    .d   (locked_in),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    retry_nxt      = retry_cnt;
    loss_nxt       = loss_cnt;
    attempt_failed = 1'b0;

    case (state)
      ST_RST: begin
        if (cnt <= ONE) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = LD_WAIT;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end

      ST_WAIT: begin
        if (relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = LD_RST;
        end else if (locked_s) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = ST_RUN;
            retry_nxt = '0;
          end else begin
            state_nxt = ST_STABLE;
            cnt_nxt   = LD_STAB;
          end
        end else if (cnt <= ONE) begin
          attempt_failed = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end

      ST_STABLE: begin
        if (relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = LD_RST;
        end else if (!locked_s) begin
          attempt_failed = 1'b1;
        end else if (cnt <= ONE) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end

      ST_RUN: begin
        // A lock loss is counted even when a relock request arrives with it.
        if (!locked_s) begin
          loss_nxt = sat_inc(loss_cnt);
        end
        if (!locked_s || relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = LD_RST;
        end
      end

      ST_FAIL: begin
        if (relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = LD_RST;
          retry_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_RST;
        cnt_nxt   = LD_RST;
      end
    endcase

    if (attempt_failed) begin
      retry_nxt = retry_cnt + RETRY_W'(1);
      if (int'(retry_cnt) + 1 >= MAX_RETRIES) begin
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_RST;
        cnt_nxt   = LD_RST;
      end
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as state.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= ST_RST;
      cnt       <= LD_RST;
      mmcm_rst  <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mmcm_rst  <= (state_nxt == ST_RST);
      sys_rst   <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      fail      <= (state_nxt == ST_FAIL);
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_mmcm_rst_ctrl.sv
// Directed bench for mmcm_rst_ctrl with short timing parameters; every step
// applies inputs after a clock edge and checks registered outputs 1 ns later.
module tb_mmcm_rst_ctrl;

  logic       clk;
  logic       RESET;
  logic       locked_in;
  logic       relock_req;
  logic       mmcm_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int vectors;
  int miscompares;

  mmcm_rst_ctrl #(
    .RST_PULSE_CYCLES (4),
    .LOCK_TIMEOUT     (32),
    .STABLE_CYCLES    (8),
    .MAX_RETRIES      (2)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .locked_in  (locked_in),
    .relock_req (relock_req),
    .mmcm_rst   (mmcm_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'd1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_loss"}, 32'(loss_cnt), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    locked_in   = 1'b0;
    relock_req  = 1'b0;

    // Reset values before any clock edge
    #2;
    chk_reset_vals("por");
    tick(2);
    RESET = 1'b0;

    // Normal lock: 4-cycle MMCM reset, lock raised 10 cycles after release
    tick(3);
    chk("norm_pulse_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk("norm_pulse_lo", 32'(mmcm_rst), 32'd0);
    chk("norm_sysrst_wait", 32'(sys_rst), 32'd1);
    tick(6);
    locked_in = 1'b1;
    tick(9);
    chk("norm_ready_early", 32'(ready), 32'd0);
    chk("norm_sysrst_early", 32'(sys_rst), 32'd1);
    tick(1);
    chk("norm_ready", 32'(ready), 32'd1);
    chk("norm_sysrst", 32'(sys_rst), 32'd0);
    chk("norm_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN, then relock
    tick(3);
    locked_in = 1'b0;
    tick(2);
    chk("loss_ready_hold", 32'(ready), 32'd1);
    tick(1);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_sysrst", 32'(sys_rst), 32'd1);
    chk("loss_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("loss_cnt1", 32'(loss_cnt), 32'd1);
    chk("loss_retry", 32'(retry_cnt), 32'd0);
    locked_in = 1'b1;
    tick(4);
    chk("loss_pulse_end", 32'(mmcm_rst), 32'd0);
    tick(7);
    chk("loss_relock_early", 32'(ready), 32'd0);
    tick(1);
    chk("loss_relock_ready", 32'(ready), 32'd1);
    chk("loss_cnt_keep", 32'(loss_cnt), 32'd1);

    // relock_req from RUN, then a 3-cycle lock glitch early in STABLE
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("relock_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("relock_ready", 32'(ready), 32'd0);
    chk("relock_no_loss", 32'(loss_cnt), 32'd1);
    tick(6);
    locked_in = 1'b0;
    tick(3);
    chk("glitch_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("glitch_retry", 32'(retry_cnt), 32'd1);
    chk("glitch_ready", 32'(ready), 32'd0);
    locked_in = 1'b1;
    tick(3);
    chk("glitch_pulse_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk("glitch_pulse_lo", 32'(mmcm_rst), 32'd0);
    chk("glitch_retry_hold", 32'(retry_cnt), 32'd1);
    tick(7);
    chk("glitch_ready_early", 32'(ready), 32'd0);
    tick(1);
    chk("glitch_ready", 32'(ready), 32'd1);
    chk("glitch_retry_clr", 32'(retry_cnt), 32'd0);

    // Lock loss and relock_req together in RUN; relock_req ignored in RST
    tick(2);
    locked_in = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("both_ready", 32'(ready), 32'd0);
    chk("both_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("both_loss", 32'(loss_cnt), 32'd2);
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(1);
    chk("rst_ignore_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk("rst_ignore_lo", 32'(mmcm_rst), 32'd0);

    // Asynchronous RESET while in STABLE
    locked_in = 1'b1;
    tick(5);
    chk("pre_areset_mmcm", 32'(mmcm_rst), 32'd0);
    chk("pre_areset_loss", 32'(loss_cnt), 32'd2);
    #1;
    RESET = 1'b1;
    locked_in = 1'b0;
    #2;
    chk_reset_vals("areset");
    tick(1);
    RESET = 1'b0;

    // Lock never arrives: two attempts, then FAIL after 72 cycles
    tick(35);
    chk("tmo_wait_mmcm", 32'(mmcm_rst), 32'd0);
    chk("tmo_wait_retry", 32'(retry_cnt), 32'd0);
    tick(1);
    chk("tmo_retry_pulse", 32'(mmcm_rst), 32'd1);
    chk("tmo_retry1", 32'(retry_cnt), 32'd1);
    tick(35);
    chk("tmo_fail_early", 32'(fail), 32'd0);
    tick(1);
    chk("tmo_fail", 32'(fail), 32'd1);
    chk("tmo_fail_mmcm", 32'(mmcm_rst), 32'd0);
    chk("tmo_fail_sysrst", 32'(sys_rst), 32'd1);
    chk("tmo_fail_ready", 32'(ready), 32'd0);
    tick(5);
    chk("tmo_fail_hold", 32'(fail), 32'd1);

    // Recovery from FAIL via relock_req
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    locked_in  = 1'b1;
    chk("rec_fail", 32'(fail), 32'd0);
    chk("rec_retry", 32'(retry_cnt), 32'd0);
    chk("rec_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("rec_sysrst", 32'(sys_rst), 32'd1);
    tick(3);
    chk("rec_pulse_hi", 32'(mmcm_rst), 32'd1);
    tick(1);
    chk("rec_pulse_lo", 32'(mmcm_rst), 32'd0);
    tick(7);
    chk("rec_ready_early", 32'(ready), 32'd0);
    tick(1);
    chk("rec_ready", 32'(ready), 32'd1);
    chk("rec_sysrst_lo", 32'(sys_rst), 32'd0);
    chk("rec_fail_lo", 32'(fail), 32'd0);
    chk("rec_loss", 32'(loss_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
